adder_sched: RTL

Round-robin scheduler that shares one `adder_block` (4-input signed 16-bit averaging tree, one register stage) among `NREQ` hat-sample requesters. It accepts one 4-sample bundle per cycle under valid/ready handshake and drives the shared adder. It tags each result with the requester ID and presents results through a 2-entry output FIFO with downstream backpressure. It sits between the per-hat uniform generators and the Gaussian output stage.

---
 rtl/adder_sched_pkg.sv | 28 ++
 rtl/adder_block.sv | 25 ++
 rtl/adder_sched_fifo.sv | 59 +++++
 rtl/adder_sched.sv | 81 ++++++++
 4 files changed

// File: rtl/adder_sched_pkg.sv
// Shared types and the round-robin search used by the adder scheduler.
package adder_sched_pkg;
  typedef logic signed [15:0] sample_t;
  typedef sample_t [3:0]      bundle_t;

  localparam int MAX_NREQ = 16;

  typedef struct packed {
    logic       found;
    logic [3:0] idx;
  } pick_t;

  // First valid index searching ptr, ptr+1, ... modulo n.
  function automatic pick_t rr_pick(input logic [MAX_NREQ-1:0] valid,
                                    input logic [3:0] ptr, input int n);
    pick_t p;
    int    j;
    p = '0;
    for (int k = 0; k < MAX_NREQ; k++) begin
      j = (int'(ptr) + k) % n;
      if (k < n && !p.found && valid[j]) begin
        p.found = 1'b1;
        p.idx   = 4'(j);
      end
    end
    return p;
  endfunction
endpackage

// File: rtl/adder_block.sv
// 4-input signed averaging tree: floor((floor((a+b)/2) + floor((c+d)/2))/2), one register.
module adder_block
  import adder_sched_pkg::*;
(
  input  logic    clk,
  input  sample_t a,
  input  sample_t b,
  input  sample_t c,
  input  sample_t d,
  output sample_t outp
);
  logic signed [16:0] sab, scd, sh;
  sample_t hab, hcd;

  // Dropping bit 0 of a signed sum is a floor divide by two.
  always_comb begin
    sab = {a[15], a} + {b[15], b};
    scd = {c[15], c} + {d[15], d};
    hab = sab[16:1];
    hcd = scd[16:1];
    sh  = {hab[15], hab} + {hcd[15], hcd};
  end

  always_ff @(posedge clk) outp <= sh[16:1];
endmodule

// File: rtl/adder_sched_fifo.sv
// 2-entry result FIFO of {id, sample}; slot 0 is the registered head.
module adder_sched_fifo
  import adder_sched_pkg::*;
#(
  parameter int IDW = 2
) (
  input  logic           clk,
  input  logic           reset_n,
  input  logic           push,
  input  logic [IDW-1:0] push_id,
  input  sample_t        push_data,
  input  logic           pop,
  output logic [1:0]     count,
  output logic [IDW-1:0] head_id,
  output sample_t        head_data
);
  logic [IDW-1:0] id_q   [2];
  sample_t        data_q [2];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
      for (int i = 0; i < 2; i++) begin
        id_q[i]   <= '0;
        data_q[i] <= '0;
      end
    end else begin
      case ({push, pop})
        2'b10: begin
          if (count == 2'd0) begin
            id_q[0] <= push_id; data_q[0] <= push_data;
          end else begin
            id_q[1] <= push_id; data_q[1] <= push_data;
          end
          count <= count + 2'd1;
        end
        2'b01: begin
          id_q[0] <= id_q[1]; data_q[0] <= data_q[1];
          count   <= count - 2'd1;
        end
        2'b11: begin
          if (count == 2'd1) begin
            id_q[0] <= push_id; data_q[0] <= push_data;
          end else begin
            id_q[0] <= id_q[1]; data_q[0] <= data_q[1];
            id_q[1] <= push_id; data_q[1] <= push_data;
          end
        end
        default: ;
      endcase
    end
  end

  assign head_id   = id_q[0];
  assign head_data = data_q[0];

  overflow_a: assert property (@(posedge clk) disable iff (!reset_n)
    !(push && !pop && count == 2'd2));
endmodule

// File: rtl/adder_sched.sv
// Round-robin scheduler sharing one adder_block among NREQ requesters, results via 2-entry FIFO.
module adder_sched
  import adder_sched_pkg::*;
#(
  parameter int NREQ = 4,
  parameter int IDW  = $clog2(NREQ)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [NREQ*64-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              out_valid,
  output logic [15:0]       out_data,
  output logic [IDW-1:0]    out_id,
  input  logic              out_ready
);
  logic [IDW-1:0] rr, g, id_pipe;
  logic           inflight, pop, allow, hs;
  logic [1:0]     count;
  pick_t          pick;
  bundle_t        bsel;
  sample_t        sum, head_data;

  assign pick = rr_pick(MAX_NREQ'(req_valid), 4'(rr), NREQ);
  assign g    = IDW'(pick.idx);
  assign pop  = out_valid & out_ready;
  // Accept only if the result will find room: FIFO + in-flight - pop must leave a slot.
  assign allow = ({1'b0, count} + {2'b0, inflight}) <= (3'd1 + {2'b0, pop});

  always_comb begin
    req_ready = '0;
    if (reset_n && allow && pick.found) req_ready[g] = 1'b1;
  end

  assign hs = |(req_valid & req_ready);

  always_comb begin
    bsel = '0;
    for (int i = 0; i < NREQ; i++)
      if (req_ready[i]) bsel = req_data[64*i +: 64];
  end

  adder_block u_add (
    .clk  (clk),
    .a    (bsel[0]),
    .b    (bsel[1]),
    .c    (bsel[2]),
    .d    (bsel[3]),
    .outp (sum)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rr       <= '0;
      inflight <= 1'b0;
      id_pipe  <= '0;
    end else begin
      inflight <= hs;
      if (hs) begin
        rr      <= (g == IDW'(NREQ-1)) ? '0 : g + 1'b1;
        id_pipe <= g;
      end
    end
  end

  adder_sched_fifo #(.IDW(IDW)) u_fifo (
    .clk       (clk),
    .reset_n   (reset_n),
    .push      (inflight),
    .push_id   (id_pipe),
    .push_data (sum),
    .pop       (pop),
    .count     (count),
    .head_id   (out_id),
    .head_data (head_data)
  );

  assign out_valid = (count != 2'd0);
  assign out_data  = head_data;
endmodule
